// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending-machine session timer.
// Contents:
//   state_e  - session FSM state (StIdle, StRun, StExpired), 2-bit encoding
//   bcd_t    - one BCD digit
//   tens_of / ones_of - split a 0..99 seconds constant into BCD digits
//   bcd_le   - compare two 2-digit BCD values (a <= b) without binary conversion
package vend_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRun     = 2'd1,
        StExpired = 2'd2
    } state_e;

    typedef logic [3:0] bcd_t;

    localparam int unsigned TimeoutSecsDefault = 30;
    localparam int unsigned WarnSecsDefault    = 5;

    function automatic bcd_t tens_of(input int unsigned secs);
        return bcd_t'((secs / 10) % 10);
    endfunction

    function automatic bcd_t ones_of(input int unsigned secs);
        return bcd_t'(secs % 10);
    endfunction

    // Tens digit dominates; ones only matter when the tens digits are equal.
    function automatic logic bcd_le(input bcd_t a_tens, input bcd_t a_ones,
                                    input bcd_t b_tens, input bcd_t b_ones);
        return (a_tens < b_tens) || ((a_tens == b_tens) && (a_ones <= b_ones));
    endfunction

endpackage

// File: rtl/bcd_down_counter_2d.sv
// Two-digit BCD down counter (00..99), saturating at 00.
// Ports:
//   clk, clr_n          - clock, asynchronous active-low reset (digits -> 00)
//   clear_i             - synchronous clear to 00 (highest priority)
//   load_i              - load load_tens_i/load_ones_i
//   load_tens_i/ones_i  - value to load
//   dec_i               - decrement by one (lowest priority)
//   tens_o/ones_o       - registered digits
//   next_tens_o/ones_o  - digits that will be registered on the next edge
//   is_one_o            - registered value equals 01
module bcd_down_counter_2d
    import vend_pkg::*;
(
    input  logic clk,
    input  logic clr_n,
    input  logic clear_i,
    input  logic load_i,
    input  bcd_t load_tens_i,
    input  bcd_t load_ones_i,
    input  logic dec_i,
    output bcd_t tens_o,
    output bcd_t ones_o,
    output bcd_t next_tens_o,
    output bcd_t next_ones_o,
    output logic is_one_o
);

    bcd_t tens_q, tens_d;
    bcd_t ones_q, ones_d;

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (clear_i) begin
            tens_d = 4'd0;
            ones_d = 4'd0;
        end else if (load_i) begin
            tens_d = load_tens_i;
            ones_d = load_ones_i;
        end else if (dec_i) begin
            if (ones_q != 4'd0) begin
                ones_d = ones_q - 4'd1;
            end else if (tens_q != 4'd0) begin
                // Borrow from the tens digit; 00 stays at 00.
                ones_d = 4'd9;
                tens_d = tens_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            tens_q <= 4'd0;
            ones_q <= 4'd0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens_o      = tens_q;
    assign ones_o      = ones_q;
    assign next_tens_o = tens_d;
    assign next_ones_o = ones_d;
    assign is_one_o    = (tens_q == 4'd0) && (ones_q == 4'd1);

endmodule

// File: rtl/vend_session_timer.sv
// Customer session timeout for the vending machine. Counts down TIMEOUT_SECS
// whole seconds on tick_1hz, restarts on start/kick, and flags expiry.
// Optional feature macro: WARN_BLINK_EN (warn blinks at 0.5 Hz inside the
// warning window instead of holding a steady level).
// Ports:
//   clk, clr_n        - 100 MHz clock, asynchronous active-low reset
//   tick_1hz          - one-cycle enable from the 1 Hz stage
//   start, kick, stop - session control (priority stop > start > kick > tick)
//   active, expired   - high in RUN / EXPIRED
//   timeout_pulse     - one cycle on entry to EXPIRED
//   warn              - remaining seconds <= WARN_SECS while running
//   secs_tens/ones    - remaining seconds as BCD digits
module vend_session_timer
    import vend_pkg::*;
#(
    parameter int unsigned TIMEOUT_SECS = TimeoutSecsDefault,
    parameter int unsigned WARN_SECS    = WarnSecsDefault
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       tick_1hz,
    input  logic       start,
    input  logic       kick,
    input  logic       stop,
    output logic       active,
    output logic       expired,
    output logic       timeout_pulse,
    output logic       warn,
    output logic [3:0] secs_tens,
    output logic [3:0] secs_ones
);

    localparam bcd_t LoadTens = tens_of(TIMEOUT_SECS);
    localparam bcd_t LoadOnes = ones_of(TIMEOUT_SECS);
    localparam bcd_t WarnTens = tens_of(WARN_SECS);
    localparam bcd_t WarnOnes = ones_of(WARN_SECS);

    state_e state_q, state_d;
    logic   active_q, active_d;
    logic   expired_q, expired_d;
    logic   pulse_q, pulse_d;
    logic   warn_q, warn_d;
    logic   in_win_d;

    logic   cnt_clear, cnt_load, cnt_dec;
    bcd_t   next_tens, next_ones;
    logic   is_one;

    bcd_down_counter_2d u_counter (
        .clk         (clk),
        .clr_n       (clr_n),
        .clear_i     (cnt_clear),
        .load_i      (cnt_load),
        .load_tens_i (LoadTens),
        .load_ones_i (LoadOnes),
        .dec_i       (cnt_dec),
        .tens_o      (secs_tens),
        .ones_o      (secs_ones),
        .next_tens_o (next_tens),
        .next_ones_o (next_ones),
        .is_one_o    (is_one)
    );

    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        pulse_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StRun;
                    cnt_load = 1'b1;
                end
            end
            StRun: begin
                if (stop) begin
                    state_d   = StIdle;
                    cnt_clear = 1'b1;
                end else if (start || kick) begin
                    cnt_load = 1'b1;
                end else if (tick_1hz) begin
                    if (is_one) begin
                        state_d   = StExpired;
                        cnt_clear = 1'b1;
                        pulse_d   = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            StExpired: begin
                if (stop) begin
                    state_d   = StIdle;
                    cnt_clear = 1'b1;
                end else if (start) begin
                    state_d  = StRun;
                    cnt_load = 1'b1;
                end
            end
            default: begin
                state_d   = StIdle;
                cnt_clear = 1'b1;
            end
        endcase

        active_d  = (state_d == StRun);
        expired_d = (state_d == StExpired);
        // Evaluated on next-state digits so warn lines up with the displayed value.
        in_win_d  = active_d && bcd_le(next_tens, next_ones, WarnTens, WarnOnes);
    end

`ifdef WARN_BLINK_EN
    logic in_win_q;

    // Enter the window lit, then toggle on each second counted inside it.
    always_comb begin
        warn_d = 1'b0;
        if (in_win_d) begin
            if (!in_win_q) begin
                warn_d = 1'b1;
            end else if (cnt_dec) begin
                warn_d = ~warn_q;
            end else begin
                warn_d = warn_q;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            in_win_q <= 1'b0;
        end else begin
            in_win_q <= in_win_d;
        end
    end
`else
    always_comb begin
        warn_d = in_win_d;
    end
`endif

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= StIdle;
            active_q  <= 1'b0;
            expired_q <= 1'b0;
            pulse_q   <= 1'b0;
            warn_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            expired_q <= expired_d;
            pulse_q   <= pulse_d;
            warn_q    <= warn_d;
        end
    end

    assign active        = active_q;
    assign expired       = expired_q;
    assign timeout_pulse = pulse_q;
    assign warn          = warn_q;

endmodule
